// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// States, instruction classes, opcodes and immediate formats.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JUMP,
    CL_NOP,
    CL_HALT
  } iclass_e;

  localparam logic [3:0] OP_ADDI  = 4'b0110;
  localparam logic [3:0] OP_LOAD  = 4'b0111;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_ALUI  = 4'b1001;
  localparam logic [3:0] OP_ALUJ  = 4'b1010;
  localparam logic [3:0] OP_BEQ   = 4'b1011;
  localparam logic [3:0] OP_BNE   = 4'b1100;
  localparam logic [3:0] OP_JUMP  = 4'b1101;
  localparam logic [3:0] OP_NOP   = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [1:0] IMM_J    = 2'b00;
  localparam logic [1:0] IMM_I    = 2'b01;
  localparam logic [1:0] IMM_U    = 2'b10;
  localparam logic [1:0] IMM_NONE = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: class and static datapath controls.
// Nonzero bits above bit 3 make the opcode illegal (handled as NOP).
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  output iclass_e             o_cls,
  output logic                o_alu_src,
  output logic [1:0]          o_imm_src,
  output logic                o_result_src,
  output logic                o_illegal
);

  logic [3:0] w_lo;

  assign w_lo      = i_opcode[3:0];
  assign o_illegal = |(i_opcode >> 4);

  // Map the low nibble to class and static controls
  always_comb begin
    o_cls        = CL_NOP;
    o_alu_src    = 1'b0;
    o_imm_src    = IMM_NONE;
    o_result_src = 1'b0;
    if (!o_illegal) begin
      unique case (1'b1)
        (w_lo <= 4'd5): o_cls = CL_ALU;
        (w_lo == OP_ADDI): begin
          o_cls     = CL_ALU;
          o_alu_src = 1'b1;
          o_imm_src = IMM_U;
        end
        (w_lo == OP_LOAD): begin
          o_cls        = CL_LOAD;
          o_alu_src    = 1'b1;
          o_imm_src    = IMM_I;
          o_result_src = 1'b1;
        end
        (w_lo == OP_STORE): begin
          o_cls     = CL_STORE;
          o_alu_src = 1'b1;
          o_imm_src = IMM_I;
        end
        (w_lo == OP_ALUI): begin
          o_cls     = CL_ALU;
          o_alu_src = 1'b1;
          o_imm_src = IMM_I;
        end
        (w_lo == OP_ALUJ): begin
          o_cls     = CL_ALU;
          o_alu_src = 1'b1;
          o_imm_src = IMM_J;
        end
        (w_lo == OP_BEQ),
        (w_lo == OP_BNE): begin
          o_cls     = CL_BRANCH;
          o_imm_src = IMM_I;
        end
        (w_lo == OP_JUMP): begin
          o_cls     = CL_JUMP;
          o_imm_src = IMM_J;
        end
        (w_lo == OP_NOP):  o_cls = CL_NOP;
        (w_lo == OP_HALT): o_cls = CL_HALT;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM with memory handshakes and retire counter.
// Static controls come from the live opcode in DECODE, then the latch.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_ready,
  input  logic                data_ready,
  input  logic                alu_zero,
  output logic                instr_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                data_req,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src,
  output logic [1:0]          imm_src,
  output logic                result_src,
  output logic                reg_write,
  output logic                branch,
  output logic                jump,
  output logic                illegal_op,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
);

  state_e              r_state;
  state_e              w_next;
  logic [OPCODE_W-1:0] r_opcode;
  logic [OPCODE_W-1:0] w_op;
  logic [CNT_W-1:0]    r_retired;
  iclass_e             w_cls;
  logic                w_alu_src;
  logic [1:0]          w_imm_src;
  logic                w_result_src;
  logic                w_illegal;
  logic                w_retire;
  logic                w_taken;
  logic                w_static;

  assign w_op = (r_state == ST_DECODE) ? opcode : r_opcode;

  ctrl_decode #(
    .OPCODE_W(OPCODE_W)
  ) u_dec (
    .i_opcode    (w_op),
    .o_cls       (w_cls),
    .o_alu_src   (w_alu_src),
    .o_imm_src   (w_imm_src),
    .o_result_src(w_result_src),
    .o_illegal   (w_illegal)
  );

  assign w_taken  = (w_op[3:0] == OP_BNE) ? ~alu_zero : alu_zero;
  assign w_static = (r_state == ST_DECODE)
                 || (r_state == ST_EXECUTE)
                 || (r_state == ST_MEM)
                 || (r_state == ST_WRITEBACK);

  assign alu_src    = w_static & w_alu_src;
  assign imm_src    = w_static ? w_imm_src : IMM_NONE;
  assign result_src = w_static & w_result_src;
  assign retired    = r_retired;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Opcode latch, captured on the DECODE cycle
  always_ff @(posedge clk) begin
    if (!rst_n)                     r_opcode <= '0;
    else if (r_state == ST_DECODE) r_opcode <= opcode;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n)        r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + CNT_W'(1);
  end

  // Next-state and strobe generation
  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    instr_req  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    data_req   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    illegal_op = 1'b0;
    halted     = 1'b0;
    unique case (r_state)
      ST_IDLE: w_next = ST_FETCH;
      ST_FETCH: begin
        instr_req = 1'b1;
        if (instr_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        illegal_op = w_illegal;
        if (w_cls == CL_NOP) begin
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end else if (w_cls == CL_HALT) begin
          w_retire = 1'b1;
          w_next   = ST_HALT;
        end else begin
          w_next = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (w_cls == CL_BRANCH) begin
          branch   = 1'b1;
          pc_write = w_taken;
          pc_src   = w_taken;
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end else if (w_cls == CL_JUMP) begin
          jump     = 1'b1;
          pc_write = 1'b1;
          pc_src   = 1'b1;
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end else if (w_cls == CL_LOAD
                  || w_cls == CL_STORE) begin
          w_next = ST_MEM;
        end else begin
          w_next = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        data_req  = 1'b1;
        mem_read  = (w_cls == CL_LOAD);
        mem_write = (w_cls == CL_STORE);
        if (data_ready) begin
          if (w_cls == CL_LOAD) begin
            w_next = ST_WRITEBACK;
          end else begin
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end
        end
      end
      ST_WRITEBACK: begin
        reg_write = 1'b1;
        w_retire  = 1'b1;
        w_next    = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: w_next = ST_IDLE;
    endcase
  end

endmodule
